// File: rtl/pacman_arena.sv
// pacman_arena: Pac-Man game core on a WIDTH x HEIGHT grid with NUM_GHOSTS
// chasing ghosts, candy/score tracking, a lives counter and a game-state FSM.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start                 pulse: IDLE/WON/OVER -> PLAY (restarts the game)
//   move_valid, move[1:0] player move: 00 up, 01 down, 10 left, 11 right
//   pacman_x/_y           Pac-Man position
//   ghost_x/_y            packed ghost positions, ghost g at [g*XW +: XW]
//   walls, candies        cell maps, bit x*HEIGHT+y
//   score, lives          candies eaten, lives remaining
//   state, lost, won      0 IDLE, 1 PLAY, 2 HIT, 3 WON, 4 OVER
module pacman_arena #(
  parameter int WIDTH          = 8,
  parameter int HEIGHT         = 8,
  parameter int NUM_GHOSTS     = 2,
  parameter int LIVES          = 3,
  parameter int GHOST_PERIOD   = 4,
  parameter int RESPAWN_CYCLES = 8,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT),
  localparam int SW = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     move_valid,
  input  logic [1:0]               move,
  output logic [XW-1:0]            pacman_x,
  output logic [YW-1:0]            pacman_y,
  output logic [NUM_GHOSTS*XW-1:0] ghost_x,
  output logic [NUM_GHOSTS*YW-1:0] ghost_y,
  output logic [WIDTH*HEIGHT-1:0]  walls,
  output logic [WIDTH*HEIGHT-1:0]  candies,
  output logic [SW-1:0]            score,
  output logic [3:0]               lives,
  output logic [2:0]               state,
  output logic                     lost,
  output logic                     won
);

  localparam int CELLS   = WIDTH * HEIGHT;
  localparam int CW      = $clog2(CELLS);
  localparam int MIN_DIM = (WIDTH < HEIGHT) ? WIDTH : HEIGHT;
  localparam int TW      = (GHOST_PERIOD > 1) ? $clog2(GHOST_PERIOD) : 1;
  localparam int RW      = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WON  = 3'd3,
    S_OVER = 3'd4
  } state_e;

  // Off-grid cells count as walls so movement only needs one test.
  function automatic logic is_wall(int x, int y);
    if (x < 0 || y < 0 || x >= WIDTH || y >= HEIGHT) return 1'b1;
    if (x == 0 || y == 0 || x == WIDTH-1 || y == HEIGHT-1) return 1'b1;
    return (x == y) && (x >= 2) && (x <= MIN_DIM-3);
  endfunction

  function automatic logic [CELLS-1:0] wall_map();
    logic [CELLS-1:0] m;
    m = '0;
    for (int x = 0; x < WIDTH; x++)
      for (int y = 0; y < HEIGHT; y++)
        m[x*HEIGHT+y] = is_wall(x, y);
    return m;
  endfunction

  function automatic logic [CELLS-1:0] candy_map();
    logic [CELLS-1:0] m;
    m = ~wall_map();
    m[HEIGHT+1] = 1'b0;  // Pac-Man's start cell (1,1)
    return m;
  endfunction

  localparam logic [CELLS-1:0] WALLS      = wall_map();
  localparam logic [CELLS-1:0] CANDY_INIT = candy_map();

  state_e          state_q;
  logic [XW-1:0]   pac_x_q, pac_x_d;
  logic [YW-1:0]   pac_y_q, pac_y_d;
  logic [XW-1:0]   gx_q [NUM_GHOSTS];
  logic [XW-1:0]   gx_d [NUM_GHOSTS];
  logic [YW-1:0]   gy_q [NUM_GHOSTS];
  logic [YW-1:0]   gy_d [NUM_GHOSTS];
  logic [CELLS-1:0] candies_q, candies_d;
  logic [SW-1:0]   score_q, score_d;
  logic [3:0]      lives_q;
  logic [TW-1:0]   tick_q;
  logic [RW-1:0]   hit_q;
  logic            ghost_step;
  logic            collide;
  logic            eat;
  logic [CW-1:0]   pac_idx;

  // NOTE: every always_comb output gets a default at the top so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    int tx, ty, gx, gy, dx, dy, sx, sy;
    tx = int'(pac_x_q);
    ty = int'(pac_y_q);
    gx = 0; gy = 0; dx = 0; dy = 0; sx = 0; sy = 0;
    pac_x_d = pac_x_q;
    pac_y_d = pac_y_q;
    if (state_q == S_PLAY && move_valid) begin
      case (move)
        2'b00:   ty = ty - 1;
        2'b01:   ty = ty + 1;
        2'b10:   tx = tx - 1;
        default: tx = tx + 1;
      endcase
      if (!is_wall(tx, ty)) begin
        pac_x_d = XW'(tx);
        pac_y_d = YW'(ty);
      end
    end

    // Ghosts chase the current Pac-Man position: x first, then y.
    ghost_step = (state_q == S_PLAY) && (tick_q == TW'(GHOST_PERIOD-1));
    collide    = 1'b0;
    for (int g = 0; g < NUM_GHOSTS; g++) begin
      gx_d[g] = gx_q[g];
      gy_d[g] = gy_q[g];
      if (ghost_step) begin
        gx = int'(gx_q[g]);
        gy = int'(gy_q[g]);
        dx = int'(pac_x_q) - gx;
        dy = int'(pac_y_q) - gy;
        sx = (dx > 0) ? 1 : -1;
        sy = (dy > 0) ? 1 : -1;
        if (dx != 0 && !is_wall(gx+sx, gy))      gx_d[g] = XW'(gx+sx);
        else if (dy != 0 && !is_wall(gx, gy+sy)) gy_d[g] = YW'(gy+sy);
      end
      // Same next cell, or Pac-Man and a ghost passing through each other.
      if (gx_d[g] == pac_x_d && gy_d[g] == pac_y_d) collide = 1'b1;
      if (gx_d[g] == pac_x_q && gy_d[g] == pac_y_q &&
          pac_x_d == gx_q[g] && pac_y_d == gy_q[g]) collide = 1'b1;
    end

    pac_idx   = CW'(int'(pac_x_d)*HEIGHT + int'(pac_y_d));
    eat       = (state_q == S_PLAY) && candies_q[pac_idx];
    candies_d = candies_q;
    score_d   = score_q;
    if (eat) begin
      candies_d[pac_idx] = 1'b0;
      if (score_q != '1) score_d = score_q + 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  // NOTE: the candy map is a flop vector, not a RAM, so it can and must be
  // loaded by reset; a game cannot start with an undefined board.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pac_x_q   <= XW'(1);
      pac_y_q   <= YW'(1);
      for (int g = 0; g < NUM_GHOSTS; g++) begin
        gx_q[g] <= XW'(WIDTH-2);
        gy_q[g] <= YW'(HEIGHT-2-g);
      end
      candies_q <= CANDY_INIT;
      score_q   <= '0;
      lives_q   <= 4'(LIVES);
      tick_q    <= '0;
      hit_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_WON, S_OVER: begin
          if (start) begin
            state_q   <= S_PLAY;
            pac_x_q   <= XW'(1);
            pac_y_q   <= YW'(1);
            for (int g = 0; g < NUM_GHOSTS; g++) begin
              gx_q[g] <= XW'(WIDTH-2);
              gy_q[g] <= YW'(HEIGHT-2-g);
            end
            candies_q <= CANDY_INIT;
            score_q   <= '0;
            lives_q   <= 4'(LIVES);
            tick_q    <= '0;
            hit_q     <= '0;
          end
        end
        S_PLAY: begin
          candies_q <= candies_d;
          score_q   <= score_d;
          tick_q    <= ghost_step ? '0 : tick_q + 1'b1;
          pac_x_q   <= pac_x_d;
          pac_y_q   <= pac_y_d;
          gx_q      <= gx_d;
          gy_q      <= gy_d;
          if (collide && lives_q == 4'd1) begin
            lives_q <= 4'd0;
            state_q <= S_OVER;
          end else if (candies_d == '0) begin
            state_q <= S_WON;
          end else if (collide) begin
            // Respawn overrides the positions just computed.
            lives_q <= lives_q - 4'd1;
            state_q <= S_HIT;
            hit_q   <= '0;
            pac_x_q <= XW'(1);
            pac_y_q <= YW'(1);
            for (int g = 0; g < NUM_GHOSTS; g++) begin
              gx_q[g] <= XW'(WIDTH-2);
              gy_q[g] <= YW'(HEIGHT-2-g);
            end
          end
        end
        S_HIT: begin
          if (hit_q == RW'(RESPAWN_CYCLES-1)) begin
            state_q <= S_PLAY;
            tick_q  <= '0;
          end else begin
            hit_q <= hit_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost_out
    assign ghost_x[g*XW +: XW] = gx_q[g];
    assign ghost_y[g*YW +: YW] = gy_q[g];
  end

  assign pacman_x = pac_x_q;
  assign pacman_y = pac_y_q;
  assign walls    = WALLS;
  assign candies  = candies_q;
  assign score    = score_q;
  assign lives    = lives_q;
  assign state    = state_q;
  assign lost     = (state_q == S_OVER);
  assign won      = (state_q == S_WON);

endmodule

// File: tb/tb_pacman_arena.sv
// Bench for pacman_arena: a game-level model (integer coordinates, 2-D candy
// array) is stepped on every clock and compared against every output on each
// falling edge, under directed play and randomized moves/starts/resets.
module tb_pacman_arena;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int NG = 2;
  localparam int LV = 3;
  localparam int GP = 4;
  localparam int RC = 8;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int SW = $clog2(W*H+1);
  localparam int CELLS = W*H;
  localparam int SMAX  = (1 << SW) - 1;
  localparam int MINWH = (W < H) ? W : H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic move_valid = 1'b0;
  logic [1:0] move = 2'b00;
  logic [XW-1:0]    pacman_x;
  logic [YW-1:0]    pacman_y;
  logic [NG*XW-1:0] ghost_x;
  logic [NG*YW-1:0] ghost_y;
  logic [CELLS-1:0] walls, candies;
  logic [SW-1:0]    score;
  logic [3:0]       lives;
  logic [2:0]       state;
  logic             lost, won;

  pacman_arena #(
    .WIDTH(W), .HEIGHT(H), .NUM_GHOSTS(NG), .LIVES(LV),
    .GHOST_PERIOD(GP), .RESPAWN_CYCLES(RC)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
    .move(move), .pacman_x(pacman_x), .pacman_y(pacman_y),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .walls(walls), .candies(candies),
    .score(score), .lives(lives), .state(state), .lost(lost), .won(won)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- game model ----------------
  int m_state, m_px, m_py, m_score, m_lives, m_tick, m_hit;
  int m_gx [NG];
  int m_gy [NG];
  bit m_candy [W][H];

  function automatic bit wall_at(int x, int y);
    if (x <= 0 || y <= 0 || x >= W-1 || y >= H-1) return 1'b1;
    return (x == y) && (x >= 2) && (x <= MINWH-3);
  endfunction

  task automatic place_start();
    m_px = 1; m_py = 1;
    for (int g = 0; g < NG; g++) begin
      m_gx[g] = W-2;
      m_gy[g] = H-2-g;
    end
  endtask

  task automatic model_init();
    m_state = 0;
    place_start();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        m_candy[x][y] = !wall_at(x, y) && !(x == 1 && y == 1);
    m_score = 0; m_lives = LV; m_tick = 0; m_hit = 0;
  endtask

  task automatic model_step();
    int npx, npy, tx, ty, left, dx, dy;
    int ngx [NG];
    int ngy [NG];
    bit coll, step;
    case (m_state)
      0, 3, 4: if (start) begin model_init(); m_state = 1; end
      1: begin
        npx = m_px; npy = m_py;
        if (move_valid) begin
          tx = m_px; ty = m_py;
          if (move == 2'd0) ty--;
          else if (move == 2'd1) ty++;
          else if (move == 2'd2) tx--;
          else tx++;
          if (!wall_at(tx, ty)) begin npx = tx; npy = ty; end
        end
        step = (m_tick == GP-1);
        m_tick = (m_tick + 1) % GP;
        coll = 1'b0;
        for (int g = 0; g < NG; g++) begin
          ngx[g] = m_gx[g]; ngy[g] = m_gy[g];
          if (step) begin
            dx = m_px - m_gx[g];
            dy = m_py - m_gy[g];
            if (dx != 0) begin
              if (!wall_at(m_gx[g] + (dx > 0 ? 1 : -1), m_gy[g]))
                ngx[g] = m_gx[g] + (dx > 0 ? 1 : -1);
              else if (dy != 0 && !wall_at(m_gx[g], m_gy[g] + (dy > 0 ? 1 : -1)))
                ngy[g] = m_gy[g] + (dy > 0 ? 1 : -1);
            end else if (dy != 0 && !wall_at(m_gx[g], m_gy[g] + (dy > 0 ? 1 : -1))) begin
              ngy[g] = m_gy[g] + (dy > 0 ? 1 : -1);
            end
          end
          if (ngx[g] == npx && ngy[g] == npy) coll = 1'b1;
          if (ngx[g] == m_px && ngy[g] == m_py && npx == m_gx[g] && npy == m_gy[g]) coll = 1'b1;
        end
        if (m_candy[npx][npy]) begin
          m_candy[npx][npy] = 1'b0;
          if (m_score < SMAX) m_score++;
        end
        left = 0;
        for (int x = 0; x < W; x++)
          for (int y = 0; y < H; y++)
            left += int'(m_candy[x][y]);
        m_px = npx; m_py = npy;
        for (int g = 0; g < NG; g++) begin m_gx[g] = ngx[g]; m_gy[g] = ngy[g]; end
        if (coll && m_lives == 1) begin
          m_lives = 0; m_state = 4;
        end else if (left == 0) begin
          m_state = 3;
        end else if (coll) begin
          m_lives--; m_state = 2; m_hit = 0; place_start();
        end
      end
      2: begin
        m_hit++;
        if (m_hit == RC) begin m_state = 1; m_tick = 0; end
      end
      default: m_state = 0;
    endcase
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_init();
    else        model_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [CELLS-1:0] wv, cv;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        wv[x*H+y] = wall_at(x, y);
        cv[x*H+y] = m_candy[x][y];
      end
    check("pacman_x", 64'(pacman_x), 64'(m_px));
    check("pacman_y", 64'(pacman_y), 64'(m_py));
    for (int g = 0; g < NG; g++) begin
      check($sformatf("ghost_x%0d", g), 64'(ghost_x[g*XW +: XW]), 64'(m_gx[g]));
      check($sformatf("ghost_y%0d", g), 64'(ghost_y[g*YW +: YW]), 64'(m_gy[g]));
    end
    check("walls", 64'(walls), 64'(wv));
    check("candies", 64'(candies), 64'(cv));
    check("score", 64'(score), 64'(m_score));
    check("lives", 64'(lives), 64'(m_lives));
    check("state", 64'(state), 64'(m_state));
    check("lost", 64'(lost), 64'(m_state == 4));
    check("won", 64'(won), 64'(m_state == 3));
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    #2 reset = 1'b0;
    cyc();
    reset = 1'b1;

    // Reset state, hand-computed.
    check("rst_pac_x", 64'(pacman_x), 64'd1);
    check("rst_pac_y", 64'(pacman_y), 64'd1);
    check("rst_g0", 64'({ghost_x[0 +: XW], ghost_y[0 +: YW]}), 64'({3'd6, 3'd6}));
    check("rst_g1", 64'({ghost_x[XW +: XW], ghost_y[YW +: YW]}), 64'({3'd6, 3'd5}));
    check("rst_state", 64'(state), 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_lives", 64'(lives), 64'd3);
    check("rst_candy_cnt", 64'($countones(candies)), 64'd31);
    check("rst_wall_33", 64'(walls[3*H+3]), 64'd1);
    check("rst_wall_11", 64'(walls[1*H+1]), 64'd0);

    // Start, eat right, bump into the top border.
    start = 1'b1; cyc(); start = 1'b0;
    check("start_state", 64'(state), 64'd1);
    move_valid = 1'b1; move = 2'b11; cyc();
    check("right_pac", 64'({pacman_x, pacman_y}), 64'({3'd2, 3'd1}));
    check("right_score", 64'(score), 64'd1);
    check("right_candy", 64'(candies[2*H+1]), 64'd0);
    move = 2'b00; cyc();
    check("up_pac", 64'({pacman_x, pacman_y}), 64'({3'd2, 3'd1}));
    check("up_score", 64'(score), 64'd1);
    move_valid = 1'b0; cyc();
    check("g0_hold_c3", 64'(ghost_x[0 +: XW]), 64'd6);
    cyc();
    check("g0_step_c4", 64'({ghost_x[0 +: XW], ghost_y[0 +: YW]}), 64'({3'd5, 3'd6}));
    check("g1_step_c4", 64'({ghost_x[XW +: XW], ghost_y[YW +: YW]}), 64'({3'd6, 3'd4}));
    repeat (4) cyc();
    check("g0_step_c8", 64'({ghost_x[0 +: XW], ghost_y[0 +: YW]}), 64'({3'd4, 3'd6}));

    // Asynchronous reset mid-PLAY, observed before the next clock edge.
    #2 reset = 1'b0;
    #1;
    check("arst_pac", 64'({pacman_x, pacman_y}), 64'({3'd1, 3'd1}));
    check("arst_score", 64'(score), 64'd0);
    check("arst_state", 64'(state), 64'd0);
    check("arst_candy_cnt", 64'($countones(candies)), 64'd31);
    check("arst_g0", 64'(ghost_x[0 +: XW]), 64'd6);
    compare_all();
    cyc();
    reset = 1'b1;

    // Idle Pac-Man: ghost 1 reaches (1,1) on its 9th step (PLAY cycle 36).
    start = 1'b1; cyc(); start = 1'b0;
    repeat (35) cyc();
    check("idle_c35_state", 64'(state), 64'd1);
    cyc();
    check("hit_state", 64'(state), 64'd2);
    check("hit_lives", 64'(lives), 64'd2);
    check("hit_pac", 64'({pacman_x, pacman_y}), 64'({3'd1, 3'd1}));
    check("hit_g0", 64'({ghost_x[0 +: XW], ghost_y[0 +: YW]}), 64'({3'd6, 3'd6}));
    repeat (7) cyc();
    check("hit_c7_state", 64'(state), 64'd2);
    cyc();
    check("resume_state", 64'(state), 64'd1);
    check("resume_score", 64'(score), 64'd0);

    // Randomized play with occasional restarts and asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      start      = ($urandom_range(0, 15) == 0);
      move_valid = ($urandom_range(0, 3) != 0);
      move       = 2'($urandom_range(0, 3));
      if (i % 1000 == 700) begin
        #3 reset = 1'b0;
        #1 compare_all();
        cyc();
        reset = 1'b1;
      end else begin
        cyc();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
